mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared by fetch and data requesters
// Data port has priority; a streak guard lets a waiting fetch through after MAX_D data grants.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LAT    = 1,
   parameter int MAX_D  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [2:0] LAT_V = 3'(LAT);
   localparam logic [3:0] MAX_V = 4'(MAX_D);

   state_t     state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic [3:0] streak, streak_nx;
   logic       owner_d, owner_nx;
   logic       done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         streak  <= 4'd0;
         owner_d <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         streak  <= streak_nx;
         owner_d <= owner_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      streak_nx = streak;
      owner_nx  = owner_d;
      done      = 1'b0;
      i_gnt     = 1'b0;
      d_gnt     = 1'b0;
      i_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      m_en      = 1'b0;
      m_we      = 1'b0;
      m_addr    = i_addr;
      m_wdata   = d_wdata;
      if (!rst) begin
         if (state == WAIT) begin
            cnt_nx = cnt - 3'd1;
            // The cycle the counter expires both returns data and may grant again.
            if (cnt == 3'd1) begin
               done     = 1'b1;
               i_rvalid = !owner_d;
               d_rvalid = owner_d;
               state_nx = IDLE;
               cnt_nx   = 3'd0;
            end
         end
         if (state == IDLE || done) begin
            if (d_req && !(i_req && streak == MAX_V))
               d_gnt = 1'b1;
            else if (i_req)
               i_gnt = 1'b1;
         end
         if (d_gnt) begin
            m_en     = 1'b1;
            m_we     = d_we;
            m_addr   = d_addr;
            state_nx = WAIT;
            cnt_nx   = LAT_V;
            owner_nx = 1'b1;
         end else if (i_gnt) begin
            m_en     = 1'b1;
            state_nx = WAIT;
            cnt_nx   = LAT_V;
            owner_nx = 1'b0;
         end
         if (!i_req || i_gnt)
            streak_nx = 4'd0;
         else if (d_gnt && streak != MAX_V)
            streak_nx = streak + 4'd1;
      end
   end

   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (LAT=2, MAX_D=4)
// Stimulus pushes expected grant/rvalid events; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

   logic        clk, rst;
   logic        i_req, i_gnt, i_rvalid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        m_en, m_we;
   logic [31:0] m_addr, m_wdata, m_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(2), .MAX_D(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: unwritten words read as {A5A5, addr[15:0]}, two-cycle read pipe
   logic [31:0] mem [1024];
   logic        mem_v [1024];
   logic [31:0] pipe0, pipe1;
   initial begin
      for (int i = 0; i < 1024; i++) mem_v[i] = 1'b0;
      pipe0 = '0;
      pipe1 = '0;
   end
   always @(posedge clk) begin
      pipe1 <= pipe0;
      pipe0 <= '0;
      if (m_en && !m_we)
         pipe0 <= mem_v[m_addr[11:2]] ? mem[m_addr[11:2]] : {16'hA5A5, m_addr[15:0]};
      if (m_en && m_we) begin
         mem[m_addr[11:2]]   <= m_wdata;
         mem_v[m_addr[11:2]] <= 1'b1;
      end
   end
   assign m_rdata = pipe1;

   int cyc = 0;
   int base = 0;
   int checks = 0;
   int failures = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kinds: 0 d_rvalid, 1 i_rvalid, 2 d_gnt, 3 i_gnt
   typedef struct {int kind; int c; logic we; logic [31:0] v; logic [31:0] wd; bit chk;} ev_t;
   typedef struct {logic we; logic [31:0] a; logic [31:0] wd;} rq_t;
   ev_t sb[$];
   rq_t i_q[$];
   rq_t d_q[$];

   task automatic ex(int k, int c, logic we, logic [31:0] v, logic [31:0] wd, bit chk);
      ev_t e;
      e.kind = k; e.c = c; e.we = we; e.v = v; e.wd = wd; e.chk = chk;
      sb.push_back(e);
   endtask

   task automatic mon_ev(int kind, logic [31:0] v, logic en, logic we, logic [31:0] wd);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event got kind=%0d cyc=%0d v=%h required none", kind, cyc - base, v);
         return;
      end
      e = sb.pop_front();
      if (e.kind != kind || e.c != cyc - base || (e.chk && v !== e.v) ||
          (kind >= 2 && (en !== 1'b1 || we !== e.we || (e.we && wd !== e.wd)))) begin
         failures++;
         $display("FAIL event got kind=%0d cyc=%0d v=%h en=%b we=%b wd=%h required kind=%0d cyc=%0d v=%h we=%b wd=%h",
                  kind, cyc - base, v, en, we, wd, e.kind, e.c, e.v, e.we, e.wd);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (d_rvalid) mon_ev(0, d_rdata, 1'b0, 1'b0, 32'h0);
         if (i_rvalid) mon_ev(1, i_rdata, 1'b0, 1'b0, 32'h0);
         if (d_gnt)    mon_ev(2, m_addr, m_en, m_we, m_wdata);
         if (i_gnt)    mon_ev(3, m_addr, m_en, m_we, m_wdata);
      end
   end

   task automatic chk(string n, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", n, act, req);
      end
   endtask

   task automatic drive();
      i_req = (i_q.size() != 0);
      d_req = (d_q.size() != 0);
      if (i_req) i_addr = i_q[0].a;
      if (d_req) begin
         d_we    = d_q[0].we;
         d_addr  = d_q[0].a;
         d_wdata = d_q[0].wd;
      end
   endtask

   task automatic step();
      logic ig, dg;
      @(negedge clk);
      ig = i_gnt;
      dg = d_gnt;
      @(posedge clk);
      #1;
      if (ig && i_q.size() != 0) void'(i_q.pop_front());
      if (dg && d_q.size() != 0) void'(d_q.pop_front());
      drive();
   endtask

   task automatic start();
      base = cyc;
      drive();
   endtask

   task automatic finish_scn(string n);
      for (int k = 0; k < 200 && (sb.size() != 0 || i_q.size() != 0 || d_q.size() != 0); k++)
         step();
      checks++;
      if (sb.size() != 0 || i_q.size() != 0 || d_q.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout got pending=%0d required pending=0", n, sb.size());
         sb.delete();
         i_q.delete();
         d_q.delete();
         drive();
      end
      step();
      step();
   endtask

   function automatic rq_t rq(logic we, logic [31:0] a, logic [31:0] wd);
      rq_t r;
      r.we = we; r.a = a; r.wd = wd;
      return r;
   endfunction

   logic [31:0] seq_a [11] = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h300, 32'h210,
                               32'h214, 32'h218, 32'h21C, 32'h304, 32'h220};
   bit          seq_i [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

   initial begin
      rst = 1'b1;
      i_req = 1'b1; i_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h14; d_wdata = 32'h1234;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_i_gnt", {31'b0, i_gnt}, 32'h0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
      chk("rst_m_en", {31'b0, m_en}, 32'h0);
      chk("rst_m_we", {31'b0, m_we}, 32'h0);
      chk("rst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
      chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);

      // fetch-only back-to-back, first grant in the first cycle after reset release
      @(posedge clk);
      #1;
      rst = 1'b0;
      i_q.push_back(rq(1'b0, 32'h0, 32'h0));
      i_q.push_back(rq(1'b0, 32'h4, 32'h0));
      i_q.push_back(rq(1'b0, 32'h8, 32'h0));
      ex(3, 0, 1'b0, 32'h0, 32'h0, 1'b1);
      ex(1, 2, 1'b0, 32'hA5A50000, 32'h0, 1'b1);
      ex(3, 2, 1'b0, 32'h4, 32'h0, 1'b1);
      ex(1, 4, 1'b0, 32'hA5A50004, 32'h0, 1'b1);
      ex(3, 4, 1'b0, 32'h8, 32'h0, 1'b1);
      ex(1, 6, 1'b0, 32'hA5A50008, 32'h0, 1'b1);
      start();
      finish_scn("fetch_only");

      // simultaneous requests: data first, fetch granted on the data rvalid cycle
      i_q.push_back(rq(1'b0, 32'h40, 32'h0));
      d_q.push_back(rq(1'b0, 32'h100, 32'h0));
      ex(2, 0, 1'b0, 32'h100, 32'h0, 1'b1);
      ex(0, 2, 1'b0, 32'hA5A50100, 32'h0, 1'b1);
      ex(3, 2, 1'b0, 32'h40, 32'h0, 1'b1);
      ex(1, 4, 1'b0, 32'hA5A50040, 32'h0, 1'b1);
      start();
      finish_scn("both_req");

      // write then read back
      d_q.push_back(rq(1'b1, 32'h20, 32'hDEADBEEF));
      d_q.push_back(rq(1'b0, 32'h20, 32'h0));
      ex(2, 0, 1'b1, 32'h20, 32'hDEADBEEF, 1'b1);
      ex(0, 2, 1'b0, 32'h0, 32'h0, 1'b0);
      ex(2, 2, 1'b0, 32'h20, 32'h0, 1'b1);
      ex(0, 4, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1);
      start();
      finish_scn("write_read");

      // starvation guard: 4 data grants, 1 fetch, 4 data, 1 fetch, 1 data
      for (int k = 0; k < 11; k++) begin
         if (seq_i[k]) i_q.push_back(rq(1'b0, seq_a[k], 32'h0));
         else          d_q.push_back(rq(1'b0, seq_a[k], 32'h0));
         if (k > 0)
            ex(seq_i[k-1] ? 1 : 0, 2 * k, 1'b0, {16'hA5A5, seq_a[k-1][15:0]}, 32'h0, 1'b1);
         ex(seq_i[k] ? 3 : 2, 2 * k, 1'b0, seq_a[k], 32'h0, 1'b1);
      end
      ex(0, 22, 1'b0, 32'hA5A50220, 32'h0, 1'b1);
      start();
      finish_scn("streak");

      // reset during WAIT: transaction abandoned, pending fetch granted right after release
      i_q.push_back(rq(1'b0, 32'h500, 32'h0));
      i_q.push_back(rq(1'b0, 32'h504, 32'h0));
      ex(3, 0, 1'b0, 32'h500, 32'h0, 1'b1);
      ex(3, 2, 1'b0, 32'h504, 32'h0, 1'b1);
      ex(1, 4, 1'b0, 32'hA5A50504, 32'h0, 1'b1);
      start();
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("wrst_i_gnt", {31'b0, i_gnt}, 32'h0);
      chk("wrst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
      chk("wrst_m_en", {31'b0, m_en}, 32'h0);
      chk("wrst_i_req_pending", {31'b0, i_req}, 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      finish_scn("reset_wait");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
